stdin_hex: RTL and testbench
============================

STDIN_HEX -- requirements
Module: stdin_hex

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning word FIFO depth in 16-bit entries, power of two, at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port srst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port uart_val_i, input, 1 bit: received byte valid, from the UART receiver.
REQ-005 SHALL have port uart_data_i, input, 8 bits: received ASCII byte.
REQ-006 SHALL have port uart_rdy_o, output, 1 bit: byte accepted when uart_val_i and uart_rdy_o are both high.
REQ-007 SHALL have port stdin_val_o, output, 1 bit: a TOY stdin word is available.
REQ-008 SHALL have port stdin_data_o, output, 16 bits: the TOY stdin word.
REQ-009 SHALL have port stdin_rdy_i, input, 1 bit: the TOY core consumes the word when stdin_val_o and stdin_rdy_i are both high.
REQ-010 SHALL have port err_o, output, 1 bit: one-cycle pulse per parse error.
REQ-011 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-012 SHALL convert an ASCII hex stream into 16-bit words, 4 digits per word, most significant digit first.
REQ-013 SHALL accept digits '0'-'9', 'A'-'F' and 'a'-'f'.
REQ-014 SHALL accept separators SP (0x20), TAB (0x09), LF (0x0A) and CR (0x0D); every other byte is invalid.
REQ-015 SHALL drive uart_rdy_o = ~fifo_full, independent of uart_data_i; no byte is dropped by flow control.
REQ-016 SHALL implement parser states IDLE, ACC, WSEP and SKIP.
- IDLE: separator -> IDLE; digit -> ACC with count 1; invalid byte -> SKIP and pulse err_o.
- ACC: digit with count < 3 -> shift the nibble in and increment count; 4th digit -> push the word and go to WSEP; separator -> discard the partial word, pulse err_o, go to IDLE; invalid byte -> discard the partial word, pulse err_o, go to SKIP.
- WSEP: separator -> IDLE; digit or invalid byte -> pulse err_o, go to SKIP.
- SKIP: separator -> IDLE; any other byte -> stay in SKIP with no further err_o pulse.
REQ-017 SHALL pulse err_o for exactly the one cycle following the accepted byte that caused the error.
REQ-018 SHALL make a pushed word visible on stdin_val_o/stdin_data_o the cycle after the 4th digit is accepted (latency 1).
REQ-019 SHALL implement the FIFO as first-word-fall-through: stdin_val_o = ~empty and stdin_data_o = head entry; stdin_data_o is don't-care when empty.
REQ-020 SHALL keep stdin_data_o and stdin_val_o stable while stdin_val_o is high and stdin_rdy_i is low.
REQ-021 SHALL, on a simultaneous push and pop, update both pointers and leave level_o unchanged.
REQ-022 SHALL ignore stdin_rdy_i when the FIFO is empty.
REQ-023 SHALL wrap both FIFO pointers modulo DEPTH and use an extra pointer bit to distinguish full from empty.
REQ-024 SHALL keep level_o within 0..DEPTH and update it in the same cycle as the pointers.

Reset
REQ-025 SHALL, on srst_i high at a clock edge, set the parser to IDLE, clear the digit count and accumulator, and empty the FIFO.
REQ-026 SHALL hold outputs at reset values while srst_i is high: uart_rdy_o=1, stdin_val_o=0, stdin_data_o=0, err_o=0, level_o=0.
REQ-027 SHALL let srst_i override every concurrent byte acceptance or word pop; a partial word is discarded without an err_o pulse.

Structure
REQ-028 SHALL take the ASCII separator constants, the parser state enum and the default DEPTH from the shared package toy_pkg.
REQ-029 SHALL place the FIFO in one sub-module, word_fifo (parameters DEPTH and WIDTH=16, with push, pop, full, empty and level), instantiated once.
REQ-030 SHALL implement hex-digit decode as a combinational function in toy_pkg.

Verification
REQ-031 Bench SHALL send "12aF\n" with stdin_rdy_i=1 -> one word 0x12AF appears, err_o never pulses.
REQ-032 Bench SHALL send "12\n" then "00FF " -> err_o pulses once after '\n'; only 0x00FF is delivered.
REQ-033 Bench SHALL send "12345 BEEF " -> err_o pulses once on '5'; words 0x1234 then 0xBEEF are delivered; bytes are skipped until the space.
REQ-034 Bench SHALL hold stdin_rdy_i=0 and send 5 words with DEPTH=4 -> level_o reaches 4 and uart_rdy_o drops during the 5th word; after stdin_rdy_i is raised all 5 words arrive in order with no loss.
REQ-035 Bench SHALL keep the FIFO at level 2 while pushing a word and popping in the same cycle -> level_o stays 2 and the pop order is preserved.
REQ-036 Bench SHALL assert srst_i after "AB" -> outputs take reset values; a following "0001 " delivers 0x0001 with no err_o pulse.

Source files
------------

// File: rtl/toy_pkg.sv
// toy_pkg: shared ASCII constants, parser states and hex decode for the TOY stdin path.
package toy_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  typedef enum logic [1:0] {IDLE, ACC, WSEP, SKIP} parse_state_e;
  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_t;
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    if (c >= 8'h30 && c <= 8'h39) h = '{1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) h = '{1'b1, c[3:0] + 4'd9};
    else h = '{1'b0, 4'd0};
    return h;
  endfunction
  function automatic logic is_sep(input logic [7:0] c);
    return c == ASCII_SP || c == ASCII_TAB || c == ASCII_LF || c == ASCII_CR;
  endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: first-word-fall-through FIFO with wrap-bit pointers.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign level_o = wr_q - rd_q;
  // occupancy never exceeds 2**AW, so its top bit alone flags full
  assign full_o  = level_o[AW];
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + ONE;
      if (do_pop) rd_q <= rd_q + ONE;
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/stdin_hex.sv
// stdin_hex: parses an ASCII hex byte stream into 16-bit TOY stdin words.
module stdin_hex
  import toy_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   uart_val_i,
  input  logic [7:0]             uart_data_i,
  output logic                   uart_rdy_o,
  output logic                   stdin_val_o,
  output logic [15:0]            stdin_data_o,
  input  logic                   stdin_rdy_i,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] level_o
);
  parse_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [11:0] acc_q, acc_d;
  logic err_q, err_d;
  logic full, empty, accept, push, sep;
  logic [15:0] head;
  logic [$clog2(DEPTH):0] level;
  hex_t hx;
  assign accept = uart_val_i & ~full;
  assign hx     = hex_decode(uart_data_i);
  assign sep    = is_sep(uart_data_i);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          state_d = sep ? IDLE : hx.ok ? ACC : SKIP;
          cnt_d   = hx.ok ? 2'd1 : 2'd0;
          acc_d   = {8'h00, hx.nib};
          err_d   = ~sep & ~hx.ok;
        end
        ACC: begin
          push    = hx.ok & (cnt_q == 2'd3);
          state_d = push ? WSEP : hx.ok ? ACC : sep ? IDLE : SKIP;
          cnt_d   = hx.ok & ~push ? cnt_q + 2'd1 : 2'd0;
          acc_d   = hx.ok ? {acc_q[7:0], hx.nib} : 12'h000;
          err_d   = ~hx.ok;
        end
        WSEP: begin
          state_d = sep ? IDLE : SKIP;
          err_d   = ~sep;
        end
        default: state_d = sep ? IDLE : SKIP;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end
  word_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .push_i (push),
    .data_i ({acc_q, hx.nib}),
    .pop_i  (stdin_rdy_i),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );
  // reset values are forced combinationally so they hold from the first reset cycle
  assign uart_rdy_o   = srst_i | ~full;
  assign stdin_val_o  = ~srst_i & ~empty;
  assign stdin_data_o = srst_i ? 16'h0000 : head;
  assign err_o        = ~srst_i & err_q;
  assign level_o      = srst_i ? '0 : level;
endmodule

// File: tb/tb_stdin_hex.sv
// tb_stdin_hex: token-level reference model with word/error scoreboards for stdin_hex.
module tb_stdin_hex;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic srst_i, uart_val_i, uart_rdy_o, stdin_val_o, stdin_rdy_i, err_o;
  logic [7:0] uart_data_i;
  logic [15:0] stdin_data_o;
  logic [2:0] level_o;
  int vecs = 0, bad = 0;
  logic [15:0] wq[$];
  bit eq[$];
  byte tq[$];

  always #5 clk = ~clk;

  stdin_hex #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .srst_i(srst_i), .uart_val_i(uart_val_i), .uart_data_i(uart_data_i),
    .uart_rdy_o(uart_rdy_o), .stdin_val_o(stdin_val_o), .stdin_data_o(stdin_data_o),
    .stdin_rdy_i(stdin_rdy_i), .err_o(err_o), .level_o(level_o)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hex(byte c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic bit is_sp(byte c);
    return c == " " || c == "\t" || c == "\n" || c == "\r";
  endfunction

  // Model: a token is the run of bytes between separators; a token yields a word when its
  // first four bytes are hex, and has exactly one error unless it is exactly four hex digits.
  task automatic put_byte(byte c);
    int n, h, t;
    bit e, w;
    logic [15:0] v;
    w = 0;
    if (is_sp(c)) begin
      n = tq.size();
      h = 0;
      while (h < n && is_hex(tq[h])) h++;
      e = n > 0 && n < 4 && h == n;
      tq.delete();
    end else begin
      tq.push_back(c);
      n = tq.size();
      h = 0;
      while (h < n && is_hex(tq[h])) h++;
      e = (n == 5 && h >= 4) || (n <= 4 && h == n - 1 && !is_hex(c));
      w = n == 4 && h == 4;
    end
    eq.push_back(e);
    if (w) begin
      v = 0;
      for (int k = 0; k < 4; k++)
        v = {v[11:0], tq[k] <= "9" ? 4'(tq[k] - "0") : 4'((tq[k] | 8'h20) - "a" + 10)};
      wq.push_back(v);
    end
    uart_val_i = 1'b1;
    uart_data_i = c;
    t = 0;
    @(negedge clk);
    while (!uart_rdy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!uart_rdy_o) begin
      check("accept_timeout", 32'(t), 32'd0);
      void'(eq.pop_back());
      if (w) void'(wq.pop_back());
    end
    @(posedge clk);
    #1 uart_val_i = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) put_byte(s[i]);
  endtask

  task automatic check_reset_outs();
    check("rst_uart_rdy", uart_rdy_o, 1);
    check("rst_stdin_val", stdin_val_o, 0);
    check("rst_stdin_data", stdin_data_o, 0);
    check("rst_err", err_o, 0);
    check("rst_level", level_o, 0);
  endtask

  task automatic drain();
    int t = 0;
    stdin_rdy_i = 1'b1;
    while (wq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_words_left", wq.size(), 0);
    check("drain_level", level_o, 0);
  endtask

  bit pend = 0, pend_e = 0, hold = 0;
  logic [15:0] hold_d;
  always @(negedge clk) begin
    if (srst_i) begin
      pend = 0;
      hold = 0;
    end else begin
      if (pend) check("err_o", err_o, pend_e);
      else if (err_o) check("err_o_spurious", err_o, 0);
      if (hold) begin
        check("hold_val", stdin_val_o, 1);
        check("hold_data", stdin_data_o, hold_d);
      end
      if (stdin_val_o && stdin_rdy_i) begin
        if (wq.size() == 0) begin
          vecs++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", stdin_data_o);
        end else check("word", stdin_data_o, wq.pop_front());
      end
      hold = stdin_val_o && !stdin_rdy_i;
      hold_d = stdin_data_o;
      pend = uart_val_i && uart_rdy_o;
      if (pend) pend_e = eq.size() != 0 ? eq.pop_front() : 1'b0;
    end
  end

  initial begin
    string hs = "0123456789abcdefABCDEF";
    string ss = " \t\n\r";
    string js = "xZ!-g:G";
    int r;
    srst_i = 1'b1;
    uart_val_i = 1'b0;
    uart_data_i = 8'h00;
    stdin_rdy_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1 srst_i = 1'b0;

    stdin_rdy_i = 1'b1;
    send_str("12aF\n");
    send_str("12\n");
    send_str("00FF ");
    send_str("12345 BEEF ");
    drain();

    stdin_rdy_i = 1'b0;
    fork
      send_str("1111 2222 3333 4444 5555 ");
      begin
        repeat (40) @(posedge clk);
        #1;
        check("full_level", level_o, 4);
        check("full_uart_rdy", uart_rdy_o, 0);
        stdin_rdy_i = 1'b1;
      end
    join
    drain();

    stdin_rdy_i = 1'b0;
    send_str("AAAA BBBB ");
    check("pre_level2", level_o, 2);
    send_str("CCC");
    stdin_rdy_i = 1'b1;
    put_byte("C");
    stdin_rdy_i = 1'b0;
    check("pushpop_level", level_o, 2);
    send_str(" ");
    drain();

    send_str("AB");
    srst_i = 1'b1;
    tq.delete();
    eq.delete();
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1 srst_i = 1'b0;
    send_str("0001 ");
    drain();

    for (int i = 0; i < 300; i++) begin
      stdin_rdy_i = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 9);
      if (r < 6) put_byte(hs[$urandom_range(0, 21)]);
      else if (r < 8) put_byte(ss[$urandom_range(0, 3)]);
      else if (r < 9) put_byte(js[$urandom_range(0, 6)]);
      else put_byte(8'($urandom_range(0, 255)));
    end
    send_str(" ");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
